// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // 27 MHz / 115200 baud.
  localparam int DEFAULT_BAUD_DIV = 234;

  // Payload bits per frame.
  localparam int DATA_BITS = 8;

  // Width of an occupancy count able to hold 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored so callers may drive push/pop unconditionally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  // Head entry is visible immediately so the consumer can load it on the pop edge.
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte input into a small FIFO,
// serialized 8N1/8N2 LSB-first on a registered, idle-high line.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         uart_tx,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic              baud_last;
  logic              stop_end;
  logic              pop;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // bit_idx doubles as the stop-bit index while in STOP.
  assign stop_end  = (state == ST_STOP) && baud_last && (bit_idx == STOP_LAST);
  assign pop       = !fifo_empty && ((state == ST_IDLE) || stop_end);
  assign tx_ready  = !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Frame FSM with baud/bit counters, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state     <= ST_START;
            shift_reg <= fifo_head;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
          end
        end

        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == DATA_LAST) begin
              state   <= ST_STOP;
              bit_idx <= '0;
              uart_tx <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              tx_done <= 1'b1;
              bit_idx <= '0;
              // Chain straight into the next start bit when more data is queued.
              if (!fifo_empty) begin
                state     <= ST_START;
                shift_reg <= fifo_head;
                uart_tx   <= 1'b0;
              end else begin
                state   <= ST_IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) driven from the
// same stimulus, each checked every cycle against a frame-level model.
module tb_uart_tx_fifo;

  localparam int BAUD  = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       line_w  [2];
  logic       ready_w [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic [2:0] level_w [2];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int ts0[$];
  int ts1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int inst, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d @cyc %0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int SB   = gi + 1;
    localparam int FLEN = (9 + SB) * BAUD;

    uart_tx_fifo #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (SB)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (ready_w[gi]),
      .uart_tx    (line_w[gi]),
      .tx_busy    (busy_w[gi]),
      .tx_done    (done_w[gi]),
      .fifo_level (level_w[gi])
    );

    // Model: a byte queue plus "frame in flight" with its cycle offset t.
    byte unsigned q[$];
    bit           in_frame = 0;
    bit           done_m   = 0;
    int           t        = 0;
    logic [7:0]   cur      = '0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        in_frame = 0;
        done_m   = 0;
        t        = 0;
      end else begin
        bit push;
        bit pop;
        push   = tx_valid && (q.size() < DEPTH);
        pop    = (q.size() > 0) && (!in_frame || t == FLEN - 1);
        done_m = in_frame && (t == FLEN - 1);
        if (in_frame) begin
          t++;
          if (t == FLEN) in_frame = 0;
        end
        if (pop) begin
          cur      = q.pop_front();
          in_frame = 1;
          t        = 0;
        end
        if (push) q.push_back(tx_data);
      end
    end

    // Line level is the symbol (start, 8 data LSB-first, stops) covering cycle t.
    always @(negedge clk) begin
      int   k;
      logic exp_line;
      k = t / BAUD;
      if (!in_frame)   exp_line = 1'b1;
      else if (k == 0) exp_line = 1'b0;
      else if (k <= 8) exp_line = cur[k-1];
      else             exp_line = 1'b1;
      check("uart_tx",    gi, int'(line_w[gi]),  int'(exp_line));
      check("tx_busy",    gi, int'(busy_w[gi]),  int'(in_frame));
      check("tx_done",    gi, int'(done_w[gi]),  int'(done_m));
      check("fifo_level", gi, int'(level_w[gi]), q.size());
      check("tx_ready",   gi, int'(ready_w[gi]), int'(q.size() < DEPTH));
    end
  end

  always @(negedge clk) begin
    if (done_w[0]) ts0.push_back(cyc);
    if (done_w[1]) ts1.push_back(cyc);
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy_w[0] || busy_w[1] || level_w[0] != 0 || level_w[1] != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", 0, int'(g < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [9:0] pat;
    int dc0, dc1, nd0, k, guard, run, maxrun, nd, nlow;
    bit rdy, started;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_uart_tx",  0, int'(line_w[0]),  1);
    check("rst_tx_ready", 0, int'(ready_w[0]), 1);
    check("rst_tx_busy",  0, int'(busy_w[0]),  0);
    check("rst_level",    0, int'(level_w[0]), 0);
    check("rst_tx_done",  0, int'(done_w[0]),  0);

    // Single byte 0x61.
    repeat (3) @(negedge clk);
    tx_data = 8'h61; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    pat = '0; dc0 = -1; dc1 = -1; nd0 = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c < 80 && c % 8 == 4) pat[c/8] = line_w[0];
      if (done_w[0]) begin nd0++; if (dc0 < 0) dc0 = c; end
      if (done_w[1] && dc1 < 0) dc1 = c;
    end
    check("single_pattern",   0, int'(pat), int'(10'b1011000010));
    check("single_done_cyc",  0, dc0, 80);
    check("single_done_cnt",  0, nd0, 1);
    check("single_done_cyc2", 1, dc1, 88);
    check("single_idle_line", 0, int'(line_w[0]), 1);
    check("single_idle_busy", 0, int'(busy_w[0]), 0);

    // Burst of 0x00..0x05 with valid held.
    wait_idle();
    ts0.delete(); ts1.delete();
    k = 0; guard = 0;
    tx_valid = 1'b1; tx_data = 8'h00;
    while (k < 6 && guard < 1000) begin
      rdy = ready_w[0];
      @(negedge clk);
      guard++;
      if (rdy) begin
        k++;
        if (k == 5) check("burst_ready_drop", 0, int'(ready_w[0]), 0);
        tx_data = 8'(k);
      end
    end
    tx_valid = 1'b0;
    check("burst_accept_timeout", 0, int'(guard < 1000), 1);
    guard = 0;
    while (ts0.size() < 6 && guard < 1000) begin @(negedge clk); guard++; end
    check("burst_done_count", 0, ts0.size(), 6);
    for (int i = 1; i < 6 && i < ts0.size(); i++) check("burst_done_spacing", 0, ts0[i] - ts0[i-1], 80);

    // Stall: valid held while data toggles every cycle.
    wait_idle();
    tx_valid = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;

    // Two back-to-back zero bytes: stop period visible as one high run.
    wait_idle();
    ts0.delete(); ts1.delete();
    tx_data = 8'h00; tx_valid = 1'b1;
    repeat (2) @(negedge clk);
    tx_valid = 1'b0;
    run = 0; maxrun = 0; started = 0; guard = 0;
    while (ts1.size() < 2 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!line_w[1]) begin
        started = 1;
        if (run > maxrun) maxrun = run;
        run = 0;
      end else if (started) begin
        run++;
      end
    end
    check("sb2_done_count", 1, ts1.size(), 2);
    check("sb2_high_run",   1, maxrun, 16);
    if (ts1.size() >= 2) check("sb2_spacing", 1, ts1[1] - ts1[0], 88);
    if (ts0.size() >= 2) check("sb1_spacing", 0, ts0[1] - ts0[0], 80);

    // Random traffic.
    wait_idle();
    for (int seg = 0; seg < 15; seg++) begin
      int dens;
      dens = $urandom_range(0, 3);
      for (int c = 0; c < 100; c++) begin
        tx_valid = ($urandom_range(0, 3) < dens) ? 1'b1 : 1'b0;
        tx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;

    // Reset during data bit 3 of 0xA5 with two more bytes queued.
    wait_idle();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'h5A;
    @(negedge clk); tx_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("midrst_pre_line",  0, int'(line_w[0]),  0);
    check("midrst_pre_level", 0, int'(level_w[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_line",  i, int'(line_w[i]),  1);
      check("midrst_level", i, int'(level_w[i]), 0);
      check("midrst_busy",  i, int'(busy_w[i]),  0);
      check("midrst_done",  i, int'(done_w[i]),  0);
      check("midrst_ready", i, int'(ready_w[i]), 1);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0; nlow = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_w[0] || done_w[1]) nd++;
      if (!line_w[0] || !line_w[1]) nlow++;
    end
    check("post_rst_done", 0, nd, 0);
    check("post_rst_low",  0, nlow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
